io_bank_sequencer: RTL and testbench



---
 rtl/io_bank_sequencer.sv | 149 ++++++++++++++
 tb/tb_io_bank_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bank_sequencer.sv
// Power-up/power-down sequencer for the 3V pad-driver banks: settles on power-good,
// staggers bank enables up as a thermometer code, ramps down in reverse, and drops all banks on power loss.
module io_bank_sequencer #(
  parameter int NBANKS  = 4,
  parameter int SETTLE  = 16,
  parameter int STAGGER = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              pwr_good,
  output logic [NBANKS-1:0] bank_oe,
  output logic              tie_hold,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              pg_fault
);

  localparam int CMAX = (SETTLE > STAGGER) ? SETTLE : STAGGER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]     SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0]     STAGGER_LAST = CW'(STAGGER - 1);
  localparam logic [NBANKS-1:0] BANK_ONE     = NBANKS'(1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_SETTLE    = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              pg_sync_q, pg_sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NBANKS-1:0] bank_oe_q, bank_oe_d;
  logic              tie_hold_q, tie_hold_d;
  logic              seq_busy_q, seq_busy_d;
  logic              seq_done_q, seq_done_d;
  logic              pg_fault_q, pg_fault_d;

  always_comb begin
    sync1_d    = pwr_good;
    pg_sync_d  = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bank_oe_d  = bank_oe_q;
    pg_fault_d = pg_fault_q;
    // The fault is cleared by a dropped request; a new loss below takes precedence.
    if (!en) pg_fault_d = 1'b0;

    case (state_q)
      S_OFF: begin
        bank_oe_d = '0;
        cnt_d     = '0;
        if (en && pg_sync_q && !pg_fault_q) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!pg_sync_q || !en) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          bank_oe_d = BANK_ONE;
          cnt_d     = '0;
          state_d   = (NBANKS == 1) ? S_ON : S_RAMP_UP;
        end
      end
      S_RAMP_UP: begin
        if (!pg_sync_q) begin
          state_d    = S_OFF;
          bank_oe_d  = '0;
          cnt_d      = '0;
          pg_fault_d = 1'b1;
        end else if (!en) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == STAGGER_LAST) begin
          bank_oe_d = (bank_oe_q << 1) | BANK_ONE;
          cnt_d     = '0;
          if (bank_oe_d[NBANKS-1]) state_d = S_ON;
        end
      end
      S_ON: begin
        cnt_d = '0;
        if (!pg_sync_q) begin
          state_d    = S_OFF;
          bank_oe_d  = '0;
          pg_fault_d = 1'b1;
        end else if (!en) begin
          state_d = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (!pg_sync_q) begin
          state_d    = S_OFF;
          bank_oe_d  = '0;
          cnt_d      = '0;
          pg_fault_d = 1'b1;
        end else if (cnt_q == STAGGER_LAST) begin
          bank_oe_d = bank_oe_q >> 1;
          cnt_d     = '0;
          if (bank_oe_d == '0) state_d = S_OFF;
        end
      end
      default: begin
        state_d   = S_OFF;
        bank_oe_d = '0;
        cnt_d     = '0;
      end
    endcase

    // Status flags are decoded from the next state so they land on the same edge as it.
    tie_hold_d = (state_d != S_ON);
    seq_done_d = (state_d == S_ON);
    seq_busy_d = (state_d == S_SETTLE) || (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_OFF;
      sync1_q    <= 1'b0;
      pg_sync_q  <= 1'b0;
      cnt_q      <= '0;
      bank_oe_q  <= '0;
      tie_hold_q <= 1'b1;
      seq_busy_q <= 1'b0;
      seq_done_q <= 1'b0;
      pg_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      pg_sync_q  <= pg_sync_d;
      cnt_q      <= cnt_d;
      bank_oe_q  <= bank_oe_d;
      tie_hold_q <= tie_hold_d;
      seq_busy_q <= seq_busy_d;
      seq_done_q <= seq_done_d;
      pg_fault_q <= pg_fault_d;
    end
  end

  assign bank_oe  = bank_oe_q;
  assign tie_hold = tie_hold_q;
  assign seq_busy = seq_busy_q;
  assign seq_done = seq_done_q;
  assign pg_fault = pg_fault_q;

endmodule

// File: tb/tb_io_bank_sequencer.sv
// Bench for io_bank_sequencer: a timed vector table for power-up/power-down, plus
// hand-written sequences for abort, power-good loss and asynchronous reset.
module tb_io_bank_sequencer;

  logic       clk;
  logic       reset;
  logic       en;
  logic       pwr_good;
  logic [3:0] bank_oe;
  logic       tie_hold;
  logic       seq_busy;
  logic       seq_done;
  logic       pg_fault;

  io_bank_sequencer #(.NBANKS(4), .SETTLE(16), .STAGGER(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pwr_good (pwr_good),
    .bank_oe  (bank_oe),
    .tie_hold (tie_hold),
    .seq_busy (seq_busy),
    .seq_done (seq_done),
    .pg_fault (pg_fault)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected word layout: {bank_oe[3:0], tie_hold, seq_busy, seq_done, pg_fault}
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         edge_n = 0;
  logic       done_watch = 1'b0;

  typedef struct {
    int         cyc;
    logic       en;
    logic       pg;
    logic [3:0] oe;
    logic       tie;
    logic       busy;
    logic       done;
    logic       fault;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ev(input logic [3:0] oe, input logic tie, input logic busy,
                                    input logic done, input logic fault);
    return {oe, tie, busy, done, fault};
  endfunction

  // One clock, sampled 1 time unit after the edge, with per-cycle invariants.
  task automatic step();
    logic [3:0] o;
    @(posedge clk);
    #1;
    edge_n++;
    o = bank_oe;
    n_vec++;
    if (((o + 4'd1) & o) != 4'd0) begin
      n_bad++;
      $display("FAIL thermometer edge %0d: bank_oe=%h is not thermometer code", edge_n, o);
    end
    if (done_watch) begin
      n_vec++;
      if (seq_done !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done edge %0d: seq_done=%b required 0", edge_n, seq_done);
      end
    end
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) step();
  endtask

  task automatic compare(input string name);
    logic [7:0] e, got;
    e   = exp_q.pop_front();
    got = {bank_oe, tie_hold, seq_busy, seq_done, pg_fault};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s edge %0d: got oe=%h tie=%b busy=%b done=%b fault=%b, want oe=%h tie=%b busy=%b done=%b fault=%b",
               name, edge_n, got[7:4], got[3], got[2], got[1], got[0],
               e[7:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  task automatic expect_at(input string name, input int cyc, input logic [7:0] e);
    exp_q.push_back(e);
    run_to(cyc);
    compare(name);
  endtask

  // Holds reset for two edges with en/pwr_good already high, then releases between edges
  // so that the next rising edge is edge 0.
  task automatic do_reset();
    reset    = 1'b1;
    en       = 1'b1;
    pwr_good = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.push_back(ev(4'h0, 1, 0, 0, 0));
    compare("reset_state");
    @(negedge clk);
    reset  = 1'b0;
    edge_n = -1;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    pwr_good = 1'b0;

    // Power-up then power-down from ON (en drops for edge 51)
    vecs.push_back('{1,  1, 1, 4'h0, 1, 0, 0, 0});
    vecs.push_back('{2,  1, 1, 4'h0, 1, 1, 0, 0});
    vecs.push_back('{17, 1, 1, 4'h0, 1, 1, 0, 0});
    vecs.push_back('{18, 1, 1, 4'h1, 1, 1, 0, 0});
    vecs.push_back('{25, 1, 1, 4'h1, 1, 1, 0, 0});
    vecs.push_back('{26, 1, 1, 4'h3, 1, 1, 0, 0});
    vecs.push_back('{34, 1, 1, 4'h7, 1, 1, 0, 0});
    vecs.push_back('{41, 1, 1, 4'h7, 1, 1, 0, 0});
    vecs.push_back('{42, 1, 1, 4'hF, 0, 0, 1, 0});
    vecs.push_back('{50, 1, 1, 4'hF, 0, 0, 1, 0});
    vecs.push_back('{51, 0, 1, 4'hF, 1, 1, 0, 0});
    vecs.push_back('{58, 0, 1, 4'hF, 1, 1, 0, 0});
    vecs.push_back('{59, 0, 1, 4'h7, 1, 1, 0, 0});
    vecs.push_back('{67, 0, 1, 4'h3, 1, 1, 0, 0});
    vecs.push_back('{75, 0, 1, 4'h1, 1, 1, 0, 0});
    vecs.push_back('{82, 0, 1, 4'h1, 1, 1, 0, 0});
    vecs.push_back('{83, 0, 1, 4'h0, 1, 0, 0, 0});
    vecs.push_back('{95, 0, 1, 4'h0, 1, 0, 0, 0});

    do_reset();
    foreach (vecs[i]) begin
      en       = vecs[i].en;
      pwr_good = vecs[i].pg;
      expect_at("table", vecs[i].cyc,
                ev(vecs[i].oe, vecs[i].tie, vecs[i].busy, vecs[i].done, vecs[i].fault));
    end

    // Abort during ramp-up while bank_oe=3
    do_reset();
    done_watch = 1'b1;
    expect_at("abort_at3", 26, ev(4'h3, 1, 1, 0, 0));
    en = 1'b0;
    expect_at("abort_enter", 27, ev(4'h3, 1, 1, 0, 0));
    expect_at("abort_hold", 34, ev(4'h3, 1, 1, 0, 0));
    expect_at("abort_step1", 35, ev(4'h1, 1, 1, 0, 0));
    en = 1'b1;
    expect_at("abort_en_back", 42, ev(4'h1, 1, 1, 0, 0));
    expect_at("abort_off", 43, ev(4'h0, 1, 0, 0, 0));
    en = 1'b0;
    run_to(46);
    done_watch = 1'b0;

    // Power-good glitch while ON
    do_reset();
    expect_at("glitch_on", 45, ev(4'hF, 0, 0, 1, 0));
    pwr_good = 1'b0;
    step();
    pwr_good = 1'b1;
    expect_at("glitch_pre", 47, ev(4'hF, 0, 0, 1, 0));
    expect_at("glitch_drop", 48, ev(4'h0, 1, 0, 0, 1));
    expect_at("glitch_sticky", 60, ev(4'h0, 1, 0, 0, 1));
    en = 1'b0;
    expect_at("glitch_clear", 61, ev(4'h0, 1, 0, 0, 0));
    en = 1'b1;
    expect_at("glitch_restart", 62, ev(4'h0, 1, 1, 0, 0));
    expect_at("glitch_settle", 77, ev(4'h0, 1, 1, 0, 0));
    expect_at("glitch_bank0", 78, ev(4'h1, 1, 1, 0, 0));

    // Power-good loss during SETTLE
    do_reset();
    expect_at("settle_cnt", 11, ev(4'h0, 1, 1, 0, 0));
    pwr_good = 1'b0;
    expect_at("settle_sync", 13, ev(4'h0, 1, 1, 0, 0));
    expect_at("settle_abort", 14, ev(4'h0, 1, 0, 0, 0));
    pwr_good = 1'b1;
    expect_at("settle_wait", 16, ev(4'h0, 1, 0, 0, 0));
    expect_at("settle_again", 17, ev(4'h0, 1, 1, 0, 0));
    expect_at("settle_full", 32, ev(4'h0, 1, 1, 0, 0));
    expect_at("settle_bank0", 33, ev(4'h1, 1, 1, 0, 0));

    // Asynchronous reset mid ramp-up, then a full repeat of the nominal timing
    do_reset();
    expect_at("arst_at7", 36, ev(4'h7, 1, 1, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(ev(4'h0, 1, 0, 0, 0));
    compare("arst_immediate");
    #2;
    reset  = 1'b0;
    edge_n = -1;
    expect_at("arst_settle", 17, ev(4'h0, 1, 1, 0, 0));
    expect_at("arst_bank0", 18, ev(4'h1, 1, 1, 0, 0));
    expect_at("arst_ramp", 41, ev(4'h7, 1, 1, 0, 0));
    expect_at("arst_on", 42, ev(4'hF, 0, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
